ysyx_20020207_lsu: RTL and testbench

Load/store unit on the consumer side of the execute stage's memory-control interface. It accepts the one-cycle `ctrl_valid` strobe together with `mem_ren`/`mem_wen`, `wmask`, `load_ctrl`, the ALU address and store data. It runs the access over a valid/ready request/response memory port, performs byte-lane alignment and load sign/zero extension, and returns a one-cycle `lsu_valid` with write-back data. It sits between execute and register write-back in the multi-cycle core.

---
 rtl/ysyx_20020207_lsu_pkg.sv | 43 ++++
 rtl/ysyx_20020207_lsu_align.sv | 37 +++
 rtl/ysyx_20020207_lsu.sv | 134 +++++++++++++
 tb/tb_ysyx_20020207_lsu.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_20020207_lsu_pkg.sv
// Shared LSU types: load funct3 codes, store mask codes, FSM encoding and the alignment rule.
// Pure declarations; no latency or backpressure of its own.
package ysyx_20020207_lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RSP  = 2'd2,
    ST_DONE = 2'd3
  } lsu_state_e;

  localparam logic [2:0] LD_LB  = 3'b000;
  localparam logic [2:0] LD_LH  = 3'b001;
  localparam logic [2:0] LD_LW  = 3'b010;
  localparam logic [2:0] LD_LBU = 3'b100;
  localparam logic [2:0] LD_LHU = 3'b101;

  localparam logic [3:0] WM_SB = 4'b0001;
  localparam logic [3:0] WM_SH = 4'b0011;
  localparam logic [3:0] WM_SW = 4'b1111;

  typedef struct packed {
    logic       wen;
    logic       ren;
    logic [3:0] wmask;
    logic [2:0] load_ctrl;
  } op_t;

  // A store takes priority over a load when both enables are set.
  function automatic logic misaligned(input op_t op, input logic [1:0] off);
    logic half;
    logic word;
    if (op.wen) begin
      half = (op.wmask == WM_SH);
      word = (op.wmask == WM_SW);
    end else begin
      half = (op.load_ctrl == LD_LH) || (op.load_ctrl == LD_LHU);
      word = (op.load_ctrl == LD_LW);
    end
    return (op.wen || op.ren) && ((half && off[0]) || (word && (off != 2'b00)));
  endfunction

endpackage

// File: rtl/ysyx_20020207_lsu_align.sv
// Byte-lane placement for stores and shift plus sign/zero extension for loads.
// Purely combinational: zero latency, no flow control.
module ysyx_20020207_lsu_align #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [1:0]            off_i,
  input  logic [DATA_WIDTH-1:0] st_data_i,
  input  logic [3:0]            wmask_i,
  input  logic [2:0]            load_ctrl_i,
  input  logic [DATA_WIDTH-1:0] rdata_i,
  output logic [DATA_WIDTH-1:0] wdata_o,
  output logic [3:0]            wstrb_o,
  output logic [DATA_WIDTH-1:0] ld_ext_o
);
  import ysyx_20020207_lsu_pkg::*;

  logic [4:0]            sh_amt;
  logic [DATA_WIDTH-1:0] w;

  assign sh_amt  = {off_i, 3'b000};
  assign wdata_o = st_data_i << sh_amt;
  // Strobe bits pushed past lane 3 fall off the 4-bit result.
  assign wstrb_o = wmask_i << off_i;
  assign w       = rdata_i >> sh_amt;

  always_comb begin
    ld_ext_o = w;
    case (load_ctrl_i)
      LD_LB:   ld_ext_o = {{(DATA_WIDTH-8){w[7]}}, w[7:0]};
      LD_LH:   ld_ext_o = {{(DATA_WIDTH-16){w[15]}}, w[15:0]};
      LD_LBU:  ld_ext_o = {{(DATA_WIDTH-8){1'b0}}, w[7:0]};
      LD_LHU:  ld_ext_o = {{(DATA_WIDTH-16){1'b0}}, w[15:0]};
      default: ld_ext_o = w;
    endcase
  end

endmodule

// File: rtl/ysyx_20020207_lsu.sv
// Load/store unit: one access per ctrl_valid over a valid/ready req/rsp port; lsu_valid at T3 zero-wait, T1 for no-op/misaligned.
// Each req or rsp wait cycle adds one cycle; ctrl_valid while busy is dropped. YSYX_LSU_ALIGN_CHECK_EN enables misalignment faults.
module ysyx_20020207_lsu #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  ctrl_valid,
  input  logic                  mem_ren,
  input  logic                  mem_wen,
  input  logic [2:0]            load_ctrl,
  input  logic [3:0]            wmask,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] st_data,
  output logic                  req_valid,
  input  logic                  req_ready,
  output logic                  req_wen,
  output logic [ADDR_WIDTH-1:0] req_addr,
  output logic [DATA_WIDTH-1:0] req_wdata,
  output logic [3:0]            req_wstrb,
  input  logic                  rsp_valid,
  output logic                  rsp_ready,
  input  logic [DATA_WIDTH-1:0] rsp_rdata,
  input  logic                  rsp_err,
  output logic                  lsu_valid,
  output logic [DATA_WIDTH-1:0] ld_data,
  output logic                  fault,
  output logic                  busy
);
  import ysyx_20020207_lsu_pkg::*;

  lsu_state_e            state_q, state_d;
  op_t                   op_in, op_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] st_data_q;
  logic [DATA_WIDTH-1:0] ld_data_q, ld_data_d;
  logic                  fault_q, fault_d;
  logic                  accept;
  logic                  misalign;
  logic [DATA_WIDTH-1:0] wdata_sh, ld_ext;
  logic [3:0]            wstrb_sh;

  assign op_in  = {mem_wen, mem_ren, wmask, load_ctrl};
  assign accept = ctrl_valid && (state_q == ST_IDLE);

`ifdef YSYX_LSU_ALIGN_CHECK_EN
  assign misalign = misaligned(op_in, addr[1:0]);
`else
  assign misalign = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (ctrl_valid) begin
          if (!(mem_ren || mem_wen) || misalign) state_d = ST_DONE;
          else                                   state_d = ST_REQ;
        end
      end
      ST_REQ:  if (req_ready) state_d = ST_RSP;
      ST_RSP:  if (rsp_valid) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_valid = (state_q == ST_REQ);
    rsp_ready = (state_q == ST_RSP);
    lsu_valid = (state_q == ST_DONE);
    busy      = (state_q != ST_IDLE);
    fault     = (state_q == ST_DONE) && fault_q;
  end

  // Operands are captured only on an accepted strobe, so req_* stay frozen for the whole access.
  always_ff @(posedge clock) begin
    if (reset) begin
      op_q      <= '0;
      addr_q    <= '0;
      st_data_q <= '0;
    end else if (accept) begin
      op_q      <= op_in;
      addr_q    <= addr;
      st_data_q <= st_data;
    end
  end

  always_comb begin
    ld_data_d = ld_data_q;
    fault_d   = fault_q;
    if (accept && (state_d == ST_DONE)) begin
      ld_data_d = '0;
      fault_d   = misalign;
    end else if ((state_q == ST_RSP) && rsp_valid) begin
      fault_d   = rsp_err;
      ld_data_d = (op_q.ren && !op_q.wen && !rsp_err) ? ld_ext : '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ld_data_q <= '0;
      fault_q   <= 1'b0;
    end else begin
      ld_data_q <= ld_data_d;
      fault_q   <= fault_d;
    end
  end

  ysyx_20020207_lsu_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
    .off_i       (addr_q[1:0]),
    .st_data_i   (st_data_q),
    .wmask_i     (op_q.wmask),
    .load_ctrl_i (op_q.load_ctrl),
    .rdata_i     (rsp_rdata),
    .wdata_o     (wdata_sh),
    .wstrb_o     (wstrb_sh),
    .ld_ext_o    (ld_ext)
  );

  assign req_wen   = op_q.wen;
  assign req_addr  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
  assign req_wdata = wdata_sh;
  assign req_wstrb = op_q.wen ? wstrb_sh : 4'b0000;
  assign ld_data   = ld_data_q;

endmodule

// File: tb/tb_ysyx_20020207_lsu.sv
// Directed bench for ysyx_20020207_lsu with a cycle-stepped memory responder and hand-computed expectations.
module tb_ysyx_20020207_lsu;

  logic        clock;
  logic        reset;
  logic        ctrl_valid, mem_ren, mem_wen;
  logic [2:0]  load_ctrl;
  logic [3:0]  wmask;
  logic [31:0] addr, st_data;
  logic        req_valid, req_ready, req_wen;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic        lsu_valid, fault, busy;
  logic [31:0] ld_data;

  ysyx_20020207_lsu #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clock(clock), .reset(reset), .ctrl_valid(ctrl_valid), .mem_ren(mem_ren), .mem_wen(mem_wen),
    .load_ctrl(load_ctrl), .wmask(wmask), .addr(addr), .st_data(st_data),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .lsu_valid(lsu_valid), .ld_data(ld_data),
    .fault(fault), .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Results of the most recent run_op.
  int          r_lat, r_pulses;
  logic        r_saw_req, r_stable, r_rwen, r_flt, r_busy_t1, r_busy_after;
  logic [31:0] r_raddr, r_rwdata, r_ld, r_ld_after;
  logic [3:0]  r_rstrb;

  task automatic run_op(input logic ren, input logic wen, input logic [2:0] lc, input logic [3:0] wm,
                        input logic [31:0] a, input logic [31:0] sd, input int req_wait, input int rsp_wait,
                        input logic [31:0] rdata, input logic err, input int viol_cyc);
    int rq_w = 0;
    int rs_w = 0;
    r_lat = -1; r_pulses = 0; r_saw_req = 0; r_stable = 1; r_rwen = 0; r_flt = 0;
    r_busy_t1 = 0; r_busy_after = 1; r_raddr = 0; r_rwdata = 0; r_rstrb = 0; r_ld = 0; r_ld_after = 0;
    @(negedge clock);
    ctrl_valid = 1; mem_ren = ren; mem_wen = wen; load_ctrl = lc; wmask = wm; addr = a; st_data = sd;
    for (int cyc = 1; cyc < 60; cyc++) begin
      @(negedge clock);
      ctrl_valid = (cyc == viol_cyc);
      if (ctrl_valid) begin
        addr = 32'h8000_0100; mem_wen = 1; mem_ren = 0; st_data = 32'hFFFF_FFFF;
        if (busy) $display("note: ctrl_valid pulsed while LSU busy at cycle %0d (protocol violation)", cyc);
      end
      if (cyc == 1) r_busy_t1 = busy;
      if (r_pulses > 0 && !lsu_valid) begin
        r_ld_after = ld_data; r_busy_after = busy;
        break;
      end
      if (lsu_valid) begin
        r_pulses++;
        if (r_lat < 0) begin r_lat = cyc; r_ld = ld_data; r_flt = fault; end
      end
      if (req_valid) begin
        if (!r_saw_req) begin
          r_saw_req = 1; r_raddr = req_addr; r_rwdata = req_wdata; r_rstrb = req_wstrb; r_rwen = req_wen;
        end else if ({req_addr, req_wdata, req_wstrb, req_wen} !== {r_raddr, r_rwdata, r_rstrb, r_rwen}) begin
          r_stable = 0;
        end
        req_ready = (rq_w >= req_wait);
        rq_w++;
      end else begin
        req_ready = 0;
      end
      if (rsp_ready) begin
        rsp_valid = (rs_w >= rsp_wait);
        rsp_rdata = rsp_valid ? rdata : 32'h5A5A_5A5A;
        rsp_err   = rsp_valid ? err : 1'b1;
        rs_w++;
      end else begin
        // Junk response outside RSP must be ignored.
        rsp_valid = req_valid; rsp_err = 1; rsp_rdata = 32'h5A5A_5A5A;
      end
    end
    ctrl_valid = 0; req_ready = 0; rsp_valid = 0; rsp_err = 0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk_eq({tag, "_ctl"}, 32'({req_valid, rsp_ready, lsu_valid, fault, busy, req_wen, req_wstrb}), 0);
    chk_eq({tag, "_ld"}, ld_data, 0);
    chk_eq({tag, "_addr"}, req_addr, 0);
    chk_eq({tag, "_wdata"}, req_wdata, 0);
  endtask

  initial begin
    reset = 1; ctrl_valid = 0; mem_ren = 0; mem_wen = 0; load_ctrl = 0; wmask = 0;
    addr = 0; st_data = 0; req_ready = 0; rsp_valid = 0; rsp_rdata = 0; rsp_err = 0;
    repeat (3) @(negedge clock);
    chk_reset_outputs("por");
    reset = 0;

    run_op(1, 0, 3'b000, 4'b0000, 32'h8000_0003, 0, 0, 0, 32'h80FF_1234, 0, 0);
    chk_eq("lb_addr", r_raddr, 32'h8000_0000);
    chk_eq("lb_wen", 32'(r_rwen), 0);
    chk_eq("lb_data", r_ld, 32'hFFFF_FF80);
    chk_eq("lb_lat", r_lat, 3);
    chk_eq("lb_hold", r_ld_after, 32'hFFFF_FF80);
    chk_eq("lb_busy_t1", 32'(r_busy_t1), 1);
    chk_eq("lb_busy_after", 32'(r_busy_after), 0);

    run_op(1, 0, 3'b100, 4'b0000, 32'h8000_0003, 0, 0, 0, 32'h80FF_1234, 0, 0);
    chk_eq("lbu_data", r_ld, 32'h0000_0080);
    chk_eq("lbu_pulses", r_pulses, 1);

    run_op(1, 0, 3'b010, 4'b0000, 32'h8000_0010, 0, 0, 0, 32'h1234_5678, 0, 0);
    chk_eq("lw_data", r_ld, 32'h1234_5678);
    chk_eq("lw_lat", r_lat, 3);

    run_op(0, 0, 3'b010, 4'b0000, 32'h8000_0011, 0, 0, 0, 32'h0, 0, 0);
    chk_eq("nop_lat", r_lat, 1);
    chk_eq("nop_noreq", 32'(r_saw_req), 0);
    chk_eq("nop_ld", r_ld, 0);
    chk_eq("nop_fault", 32'(r_flt), 0);

    run_op(0, 1, 3'b000, 4'b0011, 32'h8000_0002, 32'h0000_ABCD, 0, 0, 32'h1111_1111, 0, 0);
    chk_eq("sh_strb", 32'(r_rstrb), 32'h0000_000C);
    chk_eq("sh_wdata", r_rwdata, 32'hABCD_0000);
    chk_eq("sh_wen", 32'(r_rwen), 1);
    chk_eq("sh_ld", r_ld, 0);
    chk_eq("sh_lat", r_lat, 3);

    run_op(0, 1, 3'b000, 4'b0001, 32'h8000_0005, 32'h0000_00A5, 0, 0, 32'h0, 0, 0);
    chk_eq("sb_addr", r_raddr, 32'h8000_0004);
    chk_eq("sb_strb", 32'(r_rstrb), 32'h0000_0002);
    chk_eq("sb_wdata", r_rwdata, 32'h0000_A500);

    run_op(1, 1, 3'b010, 4'b1111, 32'h8000_0020, 32'hCAFE_F00D, 0, 0, 32'h7777_7777, 0, 0);
    chk_eq("rw_wen", 32'(r_rwen), 1);
    chk_eq("rw_strb", 32'(r_rstrb), 32'h0000_000F);
    chk_eq("rw_wdata", r_rwdata, 32'hCAFE_F00D);
    chk_eq("rw_ld", r_ld, 0);

    run_op(1, 0, 3'b001, 4'b0000, 32'h8000_0006, 0, 0, 0, 32'h8001_7FFF, 0, 0);
    chk_eq("lh_data", r_ld, 32'hFFFF_8001);
    run_op(1, 0, 3'b101, 4'b0000, 32'h8000_0006, 0, 0, 0, 32'h8001_7FFF, 0, 0);
    chk_eq("lhu_data", r_ld, 32'h0000_8001);

    run_op(1, 0, 3'b010, 4'b0000, 32'h8000_0024, 0, 5, 3, 32'hDEAD_BEEF, 0, 0);
    chk_eq("bp_lat", r_lat, 11);
    chk_eq("bp_stable", 32'(r_stable), 1);
    chk_eq("bp_pulses", r_pulses, 1);
    chk_eq("bp_data", r_ld, 32'hDEAD_BEEF);

    // Reset while waiting for a response.
    @(negedge clock);
    ctrl_valid = 1; mem_ren = 1; mem_wen = 0; load_ctrl = 3'b010; wmask = 0; addr = 32'h8000_0050;
    @(negedge clock);
    ctrl_valid = 0; req_ready = 1;
    @(negedge clock);
    req_ready = 0;
    chk_eq("rst_in_rsp", 32'(rsp_ready), 1);
    reset = 1;
    @(negedge clock);
    chk_reset_outputs("rst");
    reset = 0;
    @(negedge clock);
    chk_eq("rst_idle", 32'({busy, req_valid, lsu_valid}), 0);

    run_op(1, 0, 3'b010, 4'b0000, 32'h8000_0030, 0, 0, 0, 32'hFFFF_FFFF, 1, 0);
    chk_eq("err_fault", 32'(r_flt), 1);
    chk_eq("err_ld", r_ld, 0);
    chk_eq("err_lat", r_lat, 3);

`ifdef YSYX_LSU_ALIGN_CHECK_EN
    run_op(1, 0, 3'b010, 4'b0000, 32'h8000_0002, 0, 0, 0, 32'hAABB_CCDD, 0, 0);
    chk_eq("mis_lw_lat", r_lat, 1);
    chk_eq("mis_lw_noreq", 32'(r_saw_req), 0);
    chk_eq("mis_lw_fault", 32'(r_flt), 1);
    run_op(0, 1, 3'b000, 4'b0011, 32'h8000_0001, 32'h1122_3344, 0, 0, 32'h0, 0, 0);
    chk_eq("mis_sh_fault", 32'(r_flt), 1);
    chk_eq("mis_sh_noreq", 32'(r_saw_req), 0);
`else
    run_op(1, 0, 3'b010, 4'b0000, 32'h8000_0002, 0, 0, 0, 32'hAABB_CCDD, 0, 0);
    chk_eq("mis_lw_lat", r_lat, 3);
    chk_eq("mis_lw_addr", r_raddr, 32'h8000_0000);
    chk_eq("mis_lw_data", r_ld, 32'h0000_AABB);
    chk_eq("mis_lw_fault", 32'(r_flt), 0);
    run_op(0, 1, 3'b000, 4'b1111, 32'h8000_0001, 32'h1122_3344, 0, 0, 32'h0, 0, 0);
    chk_eq("mis_sw_strb", 32'(r_rstrb), 32'h0000_000E);
    chk_eq("mis_sw_wdata", r_rwdata, 32'h2233_4400);
`endif

    run_op(1, 0, 3'b010, 4'b0000, 32'h8000_0040, 0, 3, 0, 32'h0BAD_F00D, 0, 2);
    chk_eq("viol_addr", r_raddr, 32'h8000_0040);
    chk_eq("viol_stable", 32'(r_stable), 1);
    chk_eq("viol_wen", 32'(r_rwen), 0);
    chk_eq("viol_data", r_ld, 32'h0BAD_F00D);
    chk_eq("viol_lat", r_lat, 6);
    chk_eq("viol_pulses", r_pulses, 1);
    repeat (3) @(negedge clock);
    chk_eq("viol_idle", 32'({busy, lsu_valid, req_valid}), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
